wr_sbuf_ctrl: RTL and testbench
===============================

// Module: wr_sbuf_ctrl
// PURPOSE
//  Next-generation cache write controller. Accepts accelerator writes with byte strobes into a
//  SB_DEPTH store buffer, so the accelerator is not stalled on a miss. Drains the buffer head one
//  entry at a time: lookup -> hit write to data RAM, or miss -> allocate/writeback/fill -> write -> list update.
//  Sits between the accelerator write port and the tag list, fetch engine and data RAM.
// PARAMETERS
//  ADDR_W      32  byte address width
//  DATA_W      32  write data width; multiple of 8
//  LIST_DEPTH  4   cache lines (tag entries); TAG_W = $clog2(LIST_DEPTH)
//  LIST_WIDTH  32  words per line; WOFF_W = $clog2(LIST_WIDTH)
//  SB_DEPTH    4   store-buffer entries, power of 2, >=2
// PORTS
//  clk          in   1            clock
//  rst          in   1            synchronous active-high reset
//  wr_valid/wr_ready in/out 1     accelerator write handshake
//  wr_addr      in   ADDR_W       byte address
//  wr_data      in   DATA_W       write data
//  wr_strb      in   DATA_W/8     byte enables
//  lk_req/lk_gnt out/in 1         tag-list request handshake
//  lk_cmd       out  2            LK_LOOKUP / LK_ALLOC / LK_UPDATE (pkg)
//  lk_index     out  ADDR_W       line-aligned address of head entry
//  lk_tag       out  TAG_W        tag for LK_UPDATE, else 0
//  lk_status    in   3            ST_MISS/ST_HIT/ST_BUSY; on ALLOC bit1 = victim dirty; valid with lk_gnt
//  lk_rtag      in   TAG_W        returned tag, valid with lk_gnt
//  lk_rindex    in   ADDR_W       victim line address, valid on ALLOC grant
//  fetch_req/fetch_gnt out/in 1   fetch engine handshake
//  fetch_cmd    out  2            FC_FILL / FC_WB_FILL
//  fetch_tag    out  TAG_W        line slot
//  fetch_addr   out  ADDR_W       fill address
//  fetch_wbaddr out  ADDR_W       victim address (FC_WB_FILL)
//  fetch_done   in   1            one-cycle completion pulse
//  mem_wen/mem_wready out/in 1    data RAM write handshake
//  mem_waddr    out  TAG_W+WOFF_W {tag, word offset}
//  mem_wdata    out  DATA_W       data
//  mem_wstrb    out  DATA_W/8     byte enables
//  sb_empty     out  1            buffer empty and FSM idle (fence/flush indication)
// BEHAVIOUR
//  Reset: all req/valid outs 0, wr_ready 0 in the reset cycle then 1, FSM IDLE, buffer empty, sb_empty 1.
//  Buffer: wr_ready = !full. Push on wr_valid&&wr_ready; pop when head's RAM write handshakes.
//   Push and pop in the same cycle when full is not allowed (ready is registered-full based);
//   when not full, simultaneous push+pop keeps count. Pointers wrap mod SB_DEPTH; count SB_W+1 bits.
//  FSM (state reg updates every cycle):
//   IDLE:     !empty -> LOOKUP.
//   LOOKUP:   lk_req=1,cmd=LOOKUP. On gnt: HIT -> MEM_WR (latch rtag); BUSY -> BACKOFF; MISS -> ALLOC.
//   BACKOFF:  wait 4 cycles (counter) -> LOOKUP.
//   ALLOC:    lk_req=1,cmd=ALLOC. On gnt latch rtag,rindex,dirty -> FETCH.
//   FETCH:    fetch_req=1, cmd=dirty?FC_WB_FILL:FC_FILL. On gnt -> FWAIT.
//   FWAIT:    fetch_done -> MEM_WR.
//   MEM_WR:   mem_wen=1 with head entry. On wready: pop; if entry came via miss -> UPDATE, else IDLE.
//   UPDATE:   lk_req=1,cmd=UPDATE,lk_tag=latched tag. On gnt -> IDLE.
//  Hit latency: 1 cycle push->LOOKUP req; MEM_WR the cycle after lk_gnt. Single head processed at a time;
//   writes complete strictly in accept order. Stalled handshakes hold all outputs stable.
//  mem_waddr = {tag, head_addr[WOFF_W+B-1:B]}, B=$clog2(DATA_W/8). lk_index zeroes low WOFF_W+B bits.
//  Reset mid-operation: FSM and pointers clear; partially-issued fetch/lookup is abandoned.
// CONFIGURATION
//  SBUF_COALESCE_EN defined: a push whose word address equals the tail entry (not the head being
//   drained) merges into it: data bytes replaced where wr_strb=1, strb ORed; count unchanged, wr_ready
//   stays 1 even if full. Undefined: every write allocates a new entry.
// STRUCTURE
//  wr_sbuf_pkg: LK_*/ST_*/FC_* encodings, state enum, BACKOFF_CYCLES=4.
//  Sub-module wr_sbuf_fifo (addr/data/strb storage, pointers, count, optional coalesce merge).
// TESTING
//  Hit: write addr 0x40 data 0xA5A5A5A5 strb 0xF, lk_status HIT rtag 2 -> mem_waddr {2,5'd16}, one write.
//  Dirty miss: lookup MISS, alloc status 3'b010 rindex 0x1000 -> fetch_cmd FC_WB_FILL, wbaddr 0x1000,
//   after fetch_done one RAM write then LK_UPDATE tag=rtag.
//  Full: 5 back-to-back writes, lk_gnt held 0 -> wr_ready low after 4 accepted; resumes after first pop.
//  Busy: lookup returns BUSY -> 4 idle cycles then lookup reissued; ST_HIT then writes.
//  Coalesce (EN): writes 0x80 strb 0x3 data 0x1111 then 0x80 strb 0xC data 0x22220000 while stalled ->
//   single RAM write data 0x22221111 strb 0xF; without EN two writes in order.
//  Reset asserted in FWAIT -> next cycle sb_empty 1, all req/wen 0, later writes proceed normally.

Source files
------------

// File: rtl/wr_sbuf_pkg.sv
// wr_sbuf_pkg: command/status encodings and FSM states shared by the write store-buffer controller
package wr_sbuf_pkg;
  localparam logic [1:0] LK_LOOKUP = 2'd0;
  localparam logic [1:0] LK_ALLOC = 2'd1;
  localparam logic [1:0] LK_UPDATE = 2'd2;
  localparam logic [2:0] ST_MISS = 3'd0;
  localparam logic [2:0] ST_HIT = 3'd1;
  localparam logic [2:0] ST_BUSY = 3'd4;
  localparam logic [1:0] FC_FILL = 2'd0;
  localparam logic [1:0] FC_WB_FILL = 2'd1;
  localparam int BACKOFF_CYCLES = 4;
  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_BACKOFF, S_ALLOC, S_FETCH, S_FWAIT, S_MEM_WR, S_UPDATE
  } state_t;
endpackage

// File: rtl/wr_sbuf_ctrl_fifo.sv
// wr_sbuf_fifo: store-buffer storage with pointers/count; SBUF_COALESCE_EN merges same-word pushes into the tail
module wr_sbuf_fifo #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [DATA_W/8-1:0] push_strb,
  output logic              push_ready,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [DATA_W/8-1:0] head_strb,
  output logic              empty
);
  localparam int SB_W = $clog2(SB_DEPTH);
  localparam int S = DATA_W / 8;
  localparam int B = $clog2(S);
  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [DATA_W-1:0] data_q [SB_DEPTH];
  logic [S-1:0] strb_q [SB_DEPTH];
  logic [SB_W-1:0] rptr, wptr;
  logic [SB_W:0] count;
  logic merge, push, alloc;
`ifdef SBUF_COALESCE_EN
  logic [SB_W-1:0] tail;
  assign tail = wptr - 1'b1;
  // only merge when the tail is not also the head currently being drained
  assign merge = |count[SB_W:1] && addr_q[tail][ADDR_W-1:B] == push_addr[ADDR_W-1:B];
`else
  assign merge = 1'b0;
`endif
  assign empty = count == '0;
  assign push_ready = !rst && (!count[SB_W] || merge);
  assign push = push_valid && push_ready;
  assign alloc = push && !merge;
  assign head_addr = addr_q[rptr];
  assign head_data = data_q[rptr];
  assign head_strb = strb_q[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + SB_W'(alloc);
      rptr <= rptr + SB_W'(pop);
      count <= count + (SB_W+1)'(alloc) - (SB_W+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (alloc) begin
      addr_q[wptr] <= push_addr;
      data_q[wptr] <= push_data;
      strb_q[wptr] <= push_strb;
    end
`ifdef SBUF_COALESCE_EN
    else if (push) begin
      for (int i = 0; i < S; i++)
        if (push_strb[i]) data_q[tail][8*i +: 8] <= push_data[8*i +: 8];
      strb_q[tail] <= strb_q[tail] | push_strb;
    end
`endif
  end
endmodule

// File: rtl/wr_sbuf_ctrl.sv
// wr_sbuf_ctrl: store-buffered cache write controller draining one head entry at a time through lookup/alloc/fetch/write/update
// SBUF_COALESCE_EN: same-word writes merge into the store-buffer tail entry
module wr_sbuf_ctrl
  import wr_sbuf_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LIST_DEPTH = 4,
  parameter int LIST_WIDTH = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [DATA_W/8-1:0]           wr_strb,
  output logic                          lk_req,
  input  logic                          lk_gnt,
  output logic [1:0]                    lk_cmd,
  output logic [ADDR_W-1:0]             lk_index,
  output logic [$clog2(LIST_DEPTH)-1:0] lk_tag,
  input  logic [2:0]                    lk_status,
  input  logic [$clog2(LIST_DEPTH)-1:0] lk_rtag,
  input  logic [ADDR_W-1:0]             lk_rindex,
  output logic                          fetch_req,
  input  logic                          fetch_gnt,
  output logic [1:0]                    fetch_cmd,
  output logic [$clog2(LIST_DEPTH)-1:0] fetch_tag,
  output logic [ADDR_W-1:0]             fetch_addr,
  output logic [ADDR_W-1:0]             fetch_wbaddr,
  input  logic                          fetch_done,
  output logic                          mem_wen,
  input  logic                          mem_wready,
  output logic [$clog2(LIST_DEPTH)+$clog2(LIST_WIDTH)-1:0] mem_waddr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic [DATA_W/8-1:0]           mem_wstrb,
  output logic                          sb_empty
);
  localparam int TAG_W = $clog2(LIST_DEPTH);
  localparam int WOFF_W = $clog2(LIST_WIDTH);
  localparam int B = $clog2(DATA_W / 8);
  localparam int LB = WOFF_W + B;
  localparam int BO_W = $clog2(BACKOFF_CYCLES);
  localparam logic [BO_W-1:0] BO_INIT = BO_W'(BACKOFF_CYCLES - 1);
  state_t state;
  logic [TAG_W-1:0] tag;
  logic [ADDR_W-1:0] vaddr, head_addr;
  logic dirty, miss, empty, unused_lo;
  logic [BO_W-1:0] bo;
  wr_sbuf_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SB_DEPTH(SB_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push_valid(wr_valid), .push_addr(wr_addr), .push_data(wr_data),
    .push_strb(wr_strb), .push_ready(wr_ready), .pop(mem_wen && mem_wready),
    .head_addr(head_addr), .head_data(mem_wdata), .head_strb(mem_wstrb), .empty(empty)
  );
  assign unused_lo = ^head_addr[B-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tag <= '0;
      vaddr <= '0;
      dirty <= 1'b0;
      miss <= 1'b0;
      bo <= '0;
    end else begin
      case (state)
        S_IDLE: if (!empty) state <= S_LOOKUP;
        S_LOOKUP: if (lk_gnt) begin
          tag <= lk_rtag;
          miss <= lk_status != ST_HIT;
          bo <= BO_INIT;
          state <= lk_status == ST_HIT ? S_MEM_WR : lk_status == ST_BUSY ? S_BACKOFF : S_ALLOC;
        end
        S_BACKOFF: begin
          bo <= bo - 1'b1;
          if (bo == '0) state <= S_LOOKUP;
        end
        S_ALLOC: if (lk_gnt) begin
          tag <= lk_rtag;
          vaddr <= lk_rindex;
          dirty <= lk_status[1];
          state <= S_FETCH;
        end
        S_FETCH: if (fetch_gnt) state <= S_FWAIT;
        S_FWAIT: if (fetch_done) state <= S_MEM_WR;
        S_MEM_WR: if (mem_wready) state <= miss ? S_UPDATE : S_IDLE;
        S_UPDATE: if (lk_gnt) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
  // outputs decode the state register only, so they hold steady while a handshake stalls
  assign lk_req = state inside {S_LOOKUP, S_ALLOC, S_UPDATE};
  assign lk_cmd = state == S_ALLOC ? LK_ALLOC : state == S_UPDATE ? LK_UPDATE : LK_LOOKUP;
  assign lk_index = {head_addr[ADDR_W-1:LB], {LB{1'b0}}};
  assign lk_tag = state == S_UPDATE ? tag : '0;
  assign fetch_req = state == S_FETCH;
  assign fetch_cmd = dirty ? FC_WB_FILL : FC_FILL;
  assign fetch_tag = tag;
  assign fetch_addr = lk_index;
  assign fetch_wbaddr = vaddr;
  assign mem_wen = state == S_MEM_WR;
  assign mem_waddr = {tag, head_addr[LB-1:B]};
  assign sb_empty = empty && state == S_IDLE;
endmodule

// File: tb/tb_wr_sbuf_ctrl.sv
// tb_wr_sbuf_ctrl: directed bench with a queue model of accepted writes checked every cycle
module tb_wr_sbuf_ctrl;
  import wr_sbuf_pkg::*;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } ent_t;
  logic clk = 0, rst = 1;
  logic wr_valid = 0, wr_ready;
  logic [31:0] wr_addr = 0, wr_data = 0;
  logic [3:0] wr_strb = 0;
  logic lk_req, lk_gnt = 0;
  logic [1:0] lk_cmd, lk_tag, lk_rtag = 0;
  logic [31:0] lk_index, lk_rindex = 0;
  logic [2:0] lk_status = ST_MISS;
  logic fetch_req, fetch_gnt = 0, fetch_done = 0;
  logic [1:0] fetch_cmd, fetch_tag;
  logic [31:0] fetch_addr, fetch_wbaddr;
  logic mem_wen, mem_wready = 1;
  logic [6:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0] mem_wstrb;
  logic sb_empty;
  ent_t q[$];
  int checks = 0, errors = 0, nwr = 0, w0, n;
  logic [6:0] last_waddr;
  logic [31:0] last_wdata;
  logic [3:0] last_wstrb;
  logic [1:0] cur_tag = 0;
  logic prev_rst = 0;
  always #5 clk = ~clk;
  wr_sbuf_ctrl dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_strb(wr_strb), .lk_req(lk_req), .lk_gnt(lk_gnt), .lk_cmd(lk_cmd),
    .lk_index(lk_index), .lk_tag(lk_tag), .lk_status(lk_status), .lk_rtag(lk_rtag),
    .lk_rindex(lk_rindex), .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_cmd(fetch_cmd),
    .fetch_tag(fetch_tag), .fetch_addr(fetch_addr), .fetch_wbaddr(fetch_wbaddr),
    .fetch_done(fetch_done), .mem_wen(mem_wen), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .sb_empty(sb_empty)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin : mon
    logic merge_ok;
    ent_t e;
    if (rst) begin
      chk("rst_ready", {63'd0, wr_ready}, 0);
      if (prev_rst) chk("rst_outs", {61'd0, lk_req, fetch_req, mem_wen}, 0);
      q.delete();
    end else begin
      merge_ok = 0;
`ifdef SBUF_COALESCE_EN
      merge_ok = q.size() >= 2 && q[q.size()-1].addr[31:2] == wr_addr[31:2];
`endif
      chk("wr_ready", {63'd0, wr_ready}, {63'd0, q.size() < 4 || merge_ok});
      if (sb_empty) chk("sb_empty_queue", q.size(), 0);
      if (q.size() > 0) chk("sb_empty_busy", {63'd0, sb_empty}, 0);
      if (lk_req && lk_cmd == LK_LOOKUP && q.size() > 0) begin
        chk("lk_index", lk_index, q[0].addr & 32'hFFFF_FF80);
        chk("lk_tag_lookup", lk_tag, 0);
      end
      if (mem_wen && mem_wready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL mem_write: got write to %0h expected no write", mem_waddr);
        end else begin
          chk("mem_waddr", mem_waddr, {cur_tag, q[0].addr[6:2]});
          chk("mem_wdata", mem_wdata, q[0].data);
          chk("mem_wstrb", mem_wstrb, q[0].strb);
          void'(q.pop_front());
        end
        nwr++;
        last_waddr = mem_waddr;
        last_wdata = mem_wdata;
        last_wstrb = mem_wstrb;
      end
      if (wr_valid && wr_ready) begin
        if (merge_ok) begin
          e = q[q.size()-1];
          for (int b = 0; b < 4; b++) if (wr_strb[b]) e.data[8*b +: 8] = wr_data[8*b +: 8];
          e.strb = e.strb | wr_strb;
          q[q.size()-1] = e;
        end else q.push_back('{wr_addr, wr_data, wr_strb});
      end
    end
    prev_rst = rst;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic get(input int w);
    return w == 0 ? lk_req : w == 1 ? fetch_req : mem_wen;
  endfunction
  task automatic wait_req(input int w, input string nm);
    int k = 0;
    while (!get(w) && k < 100) begin step(); k++; end
    chk(nm, {63'd0, get(w)}, 1);
  endtask
  task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int k = 0;
    wr_valid = 1; wr_addr = a; wr_data = d; wr_strb = s;
    #0;
    while (!wr_ready && k < 50) begin step(); k++; end
    chk("wr_accept", {63'd0, wr_ready}, 1);
    step();
    wr_valid = 0;
  endtask
  task automatic lk_grant(input logic [1:0] cmd, input logic [2:0] st, input logic [1:0] rt, input logic [31:0] ri);
    wait_req(0, "lk_req_wait");
    chk("lk_cmd", lk_cmd, cmd);
    if (cmd == LK_ALLOC || (cmd == LK_LOOKUP && st == ST_HIT)) cur_tag = rt;
    lk_gnt = 1; lk_status = st; lk_rtag = rt; lk_rindex = ri;
    step();
    lk_gnt = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    step(); step();
    rst = 0;
    #0;
    chk("reset_sb_empty", {63'd0, sb_empty}, 1);
    chk("reset_ready", {63'd0, wr_ready}, 1);
    chk("reset_outs", {61'd0, lk_req, fetch_req, mem_wen}, 0);
    // hit
    write(32'h40, 32'hA5A5A5A5, 4'hF);
    chk("hit_lat0", {63'd0, lk_req}, 0);
    step();
    chk("hit_lat1", {63'd0, lk_req}, 1);
    chk("hit_index", lk_index, 32'h0);
    w0 = nwr;
    lk_grant(LK_LOOKUP, ST_HIT, 2'd2, 0);
    chk("hit_wen", {63'd0, mem_wen}, 1);
    chk("hit_waddr", mem_waddr, 7'd80);
    chk("hit_wdata", mem_wdata, 32'hA5A5A5A5);
    step();
    chk("hit_nwr", nwr - w0, 1);
    chk("hit_empty", {63'd0, sb_empty}, 1);
    // dirty miss
    write(32'h2044, 32'h12345678, 4'h5);
    lk_grant(LK_LOOKUP, ST_MISS, 0, 0);
    lk_grant(LK_ALLOC, 3'b010, 2'd1, 32'h1000);
    wait_req(1, "fetch_wait");
    step(); step();
    chk("fetch_hold", {63'd0, fetch_req}, 1);
    chk("fetch_cmd", fetch_cmd, FC_WB_FILL);
    chk("fetch_wbaddr", fetch_wbaddr, 32'h1000);
    chk("fetch_addr", fetch_addr, 32'h2000);
    chk("fetch_tag", fetch_tag, 1);
    fetch_gnt = 1; step(); fetch_gnt = 0;
    repeat (3) begin
      step();
      chk("fwait_quiet", {61'd0, lk_req, fetch_req, mem_wen}, 0);
    end
    fetch_done = 1; step(); fetch_done = 0;
    chk("miss_wen", {63'd0, mem_wen}, 1);
    chk("miss_waddr", mem_waddr, 7'd49);
    w0 = nwr;
    step();
    chk("miss_nwr", nwr - w0, 1);
    chk("upd_req", {63'd0, lk_req}, 1);
    chk("upd_cmd", lk_cmd, LK_UPDATE);
    chk("upd_tag", lk_tag, 1);
    lk_grant(LK_UPDATE, ST_HIT, 0, 0);
    chk("miss_empty", {63'd0, sb_empty}, 1);
    // full
    w0 = nwr;
    for (int i = 0; i < 4; i++) write(32'h100 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
    wr_valid = 1; wr_addr = 32'h110; wr_data = 32'hC0DE0004; wr_strb = 4'hF;
    #0;
    chk("full_ready", {63'd0, wr_ready}, 0);
    step();
    chk("full_ready_hold", {63'd0, wr_ready}, 0);
    lk_grant(LK_LOOKUP, ST_HIT, 2'd3, 0);
    chk("full_ready_mw", {63'd0, wr_ready}, 0);
    step();
    chk("full_resume", {63'd0, wr_ready}, 1);
    step();
    wr_valid = 0;
    repeat (4) lk_grant(LK_LOOKUP, ST_HIT, 2'd3, 0);
    step(); step();
    chk("full_nwr", nwr - w0, 5);
    chk("full_last", last_wdata, 32'hC0DE0004);
    // busy backoff
    write(32'h200, 32'hBEEF, 4'h3);
    lk_grant(LK_LOOKUP, ST_BUSY, 0, 0);
    n = 0;
    while (!lk_req && n < 20) begin n++; step(); end
    chk("busy_backoff", n, 4);
    w0 = nwr;
    lk_grant(LK_LOOKUP, ST_HIT, 2'd1, 0);
    step();
    chk("busy_nwr", nwr - w0, 1);
    chk("busy_waddr", last_waddr, 7'd32);
    // coalesce
    w0 = nwr;
    write(32'h300, 32'h33333333, 4'hF);
    write(32'h80, 32'h00001111, 4'h3);
    write(32'h80, 32'h22220000, 4'hC);
    lk_grant(LK_LOOKUP, ST_HIT, 0, 0);
    step();
    lk_grant(LK_LOOKUP, ST_HIT, 2'd2, 0);
    step();
`ifdef SBUF_COALESCE_EN
    chk("coal_nwr", nwr - w0, 2);
    chk("coal_data", last_wdata, 32'h22221111);
    chk("coal_strb", last_wstrb, 4'hF);
`else
    lk_grant(LK_LOOKUP, ST_HIT, 2'd2, 0);
    step();
    chk("coal_nwr", nwr - w0, 3);
    chk("coal_data", last_wdata, 32'h22220000);
    chk("coal_strb", last_wstrb, 4'hC);
`endif
    chk("coal_empty", {63'd0, sb_empty}, 1);
    // reset while waiting on a fill
    write(32'h400, 32'h55, 4'h1);
    lk_grant(LK_LOOKUP, ST_MISS, 0, 0);
    lk_grant(LK_ALLOC, 3'b000, 0, 32'h3000);
    wait_req(1, "fetch_wait2");
    chk("fill_cmd", fetch_cmd, FC_FILL);
    fetch_gnt = 1; step(); fetch_gnt = 0;
    step();
    rst = 1; step(); rst = 0;
    #0;
    chk("midrst_empty", {63'd0, sb_empty}, 1);
    chk("midrst_outs", {61'd0, lk_req, fetch_req, mem_wen}, 0);
    w0 = nwr;
    write(32'h48, 32'hCAFEF00D, 4'hF);
    lk_grant(LK_LOOKUP, ST_HIT, 2'd3, 0);
    step();
    chk("post_rst_nwr", nwr - w0, 1);
    chk("post_rst_waddr", last_waddr, 7'd114);
    chk("post_rst_data", last_wdata, 32'hCAFEF00D);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
